pulse_meas: RTL and testbench
=============================

PULSE_MEAS -- requirements
Module: pulse_meas

Interface
REQ-001 Parameter CNT_W, default 24: width of period/high_time result fields.
REQ-002 Parameter AVG_LOG2, default 2: results averaged over 2^AVG_LOG2 periods.
REQ-003 Parameter TIMEOUT, default 32'd50_000_000: ad_clk cycles allowed per measurement before abort.
REQ-004 ad_clk  input  1  AD sampling clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ad_pulse  input  1  comparator pulse, synchronous to ad_clk.
REQ-007 meas_en  input  1  level enable; low forces IDLE.
REQ-008 meas_ready  input  1  consumer accepts the result.
REQ-009 meas_valid  output  1  result valid; held until accepted.
REQ-010 period  output  CNT_W  averaged period in ad_clk cycles.
REQ-011 high_time  output  CNT_W  averaged high time in ad_clk cycles.
REQ-012 no_signal  output  1  set with meas_valid when the measurement timed out.

Function
REQ-013 Edge detect SHALL use one register pulse_d0; rise = ad_pulse & ~pulse_d0; no synchronizer.
REQ-014 FSM states SHALL be IDLE, WAIT_EDGE, MEASURE, DONE.
REQ-015 IDLE -> WAIT_EDGE when meas_en=1; tmo counter cleared on entry to WAIT_EDGE.
REQ-016 WAIT_EDGE -> MEASURE on rise (edge E0): acc<=1, hacc<=1, edge_cnt<=0.
REQ-017 MEASURE, cycle without final edge: acc+1; hacc+1 if ad_pulse=1; edge_cnt+1 on rise.
REQ-018 Final edge = rise with edge_cnt == 2^AVG_LOG2-1; that cycle is not counted; period<=acc>>AVG_LOG2, high_time<=hacc>>AVG_LOG2 (truncating), no_signal<=0, go DONE.
REQ-019 meas_valid SHALL assert the cycle after the final edge; period/high_time/no_signal stable while meas_valid=1.
REQ-020 acc/hacc width CNT_W+AVG_LOG2; tmo counter 32 bits, increments every cycle in WAIT_EDGE and MEASURE.
REQ-021 tmo reaching TIMEOUT in WAIT_EDGE or MEASURE -> DONE with period=0, high_time=0, no_signal=1; timeout wins over a simultaneous final edge.
REQ-022 DONE: meas_valid=1; on meas_valid&meas_ready -> WAIT_EDGE if meas_en=1, else IDLE; meas_valid low next cycle.
REQ-023 Edges during DONE SHALL be ignored; next measurement waits for a fresh E0.
REQ-024 meas_en=0 in WAIT_EDGE or MEASURE SHALL abort to IDLE next cycle without meas_valid; in DONE result stays held until accepted, then IDLE.
REQ-025 Constant-high ad_pulse is no edge; times out per REQ-021.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, meas_valid=0, period=0, high_time=0, no_signal=0, pulse_d0=0, acc/hacc/edge_cnt/tmo=0.
REQ-027 Reset mid-measurement SHALL discard partial results; no meas_valid until a full new measurement.
REQ-028 After rst_n release with meas_en=1, IDLE->WAIT_EDGE on the first clock.

Configuration
REQ-029 Macro PULSE_MEAS_DUTY_EN defined: hacc and high_time implemented per REQ-016..018.
REQ-030 Macro undefined: hacc removed; high_time tied to 0; period, no_signal, timing unchanged.

Verification
REQ-031 Defaults, TIMEOUT=1000, ad_pulse period 10 (3 high/7 low), meas_ready=1 -> period=10, high_time=3, no_signal=0, meas_valid one cycle after 5th rise.
REQ-032 Period alternating 9/11, AVG_LOG2=2 -> period=10; high_time average of highs truncated (2,3,2,3 -> 2).
REQ-033 ad_pulse held low, TIMEOUT=1000 -> meas_valid 1000 cycles after WAIT_EDGE entry, no_signal=1, period=0.
REQ-034 meas_ready=0 for 20 cycles after meas_valid -> outputs held; edges ignored; new E0 needed after acceptance.
REQ-035 meas_en dropped after 2nd edge -> IDLE, no meas_valid; re-enable -> clean result period=10.
REQ-036 rst_n low mid-MEASURE -> all outputs 0 immediately; without PULSE_MEAS_DUTY_EN, REQ-031 stimulus -> high_time=0, period=10.

Source files
------------

// File: rtl/pulse_meas.sv
// Pulse period / high-time meter averaging over 2^AVG_LOG2 periods of ad_pulse, with a per-measurement timeout.
// Define PULSE_MEAS_DUTY_EN to build the high-time accumulator; otherwise high_time is tied to zero.
module pulse_meas #(
    parameter int          CNT_W    = 24,
    parameter int          AVG_LOG2 = 2,
    parameter logic [31:0] TIMEOUT  = 32'd50_000_000
) (
    input  logic             ad_clk,
    input  logic             rst_n,
    input  logic             ad_pulse,
    input  logic             meas_en,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             no_signal
);

    localparam int AW = CNT_W + AVG_LOG2;
    localparam int EW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [EW-1:0] LAST_EDGE = EW'((32'd1 << AVG_LOG2) - 32'd1);

    typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, DONE} state_t;

    state_t            state_q, state_d;
    logic              pulse_d0_q, pulse_d0_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [EW-1:0]     edge_cnt_q, edge_cnt_d;
    logic [31:0]       tmo_q, tmo_d;
    logic              meas_valid_q, meas_valid_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              no_signal_q, no_signal_d;

    logic              rise_s;
    logic              timeout_s;
    logic [31:0]       tmo_inc_s;
    logic              start_s;
    logic              count_s;
    logic              load_s;
    logic              tmo_fin_s;

    // FSM next state, period accumulator, timeout counter and result latching
    always_comb begin
        state_d      = state_q;
        pulse_d0_d   = ad_pulse;
        acc_d        = acc_q;
        edge_cnt_d   = edge_cnt_q;
        tmo_d        = tmo_q;
        meas_valid_d = meas_valid_q;
        period_d     = period_q;
        no_signal_d  = no_signal_q;
        start_s      = 1'b0;
        count_s      = 1'b0;
        load_s       = 1'b0;
        tmo_fin_s    = 1'b0;
        rise_s       = ad_pulse & ~pulse_d0_q;
        tmo_inc_s    = tmo_q + 32'd1;
        timeout_s    = (tmo_inc_s >= TIMEOUT);

        case (state_q)
            IDLE: begin
                if (meas_en) begin
                    state_d = WAIT_EDGE;
                    tmo_d   = 32'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_EDGE, MEASURE: begin
                tmo_d = tmo_inc_s;
                // Disable beats timeout, timeout beats a coincident final edge
                if (!meas_en) begin
                    state_d = IDLE;
                end else if (timeout_s) begin
                    tmo_fin_s = 1'b1;
                end else if (state_q == WAIT_EDGE) begin
                    if (rise_s) begin
                        start_s    = 1'b1;
                        state_d    = MEASURE;
                        acc_d      = AW'(1);
                        edge_cnt_d = {EW{1'b0}};
                    end else begin
                        state_d = WAIT_EDGE;
                    end
                end else if (rise_s && (edge_cnt_q == LAST_EDGE)) begin
                    load_s = 1'b1;
                end else begin
                    count_s = 1'b1;
                    acc_d   = acc_q + AW'(1);
                    if (rise_s) begin
                        edge_cnt_d = edge_cnt_q + EW'(1);
                    end else begin
                        edge_cnt_d = edge_cnt_q;
                    end
                end

                if (tmo_fin_s) begin
                    state_d      = DONE;
                    meas_valid_d = 1'b1;
                    period_d     = {CNT_W{1'b0}};
                    no_signal_d  = 1'b1;
                end else if (load_s) begin
                    state_d      = DONE;
                    meas_valid_d = 1'b1;
                    period_d     = acc_q[AW-1:AVG_LOG2];
                    no_signal_d  = 1'b0;
                end else begin
                    meas_valid_d = meas_valid_q;
                end
            end
            DONE: begin
                if (meas_ready) begin
                    meas_valid_d = 1'b0;
                    tmo_d        = 32'd0;
                    state_d      = meas_en ? WAIT_EDGE : IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d      = IDLE;
                meas_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pulse_d0_q   <= 1'b0;
            acc_q        <= {AW{1'b0}};
            edge_cnt_q   <= {EW{1'b0}};
            tmo_q        <= 32'd0;
            meas_valid_q <= 1'b0;
            period_q     <= {CNT_W{1'b0}};
            no_signal_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pulse_d0_q   <= pulse_d0_d;
            acc_q        <= acc_d;
            edge_cnt_q   <= edge_cnt_d;
            tmo_q        <= tmo_d;
            meas_valid_q <= meas_valid_d;
            period_q     <= period_d;
            no_signal_q  <= no_signal_d;
        end
    end

`ifdef PULSE_MEAS_DUTY_EN
    logic [AW-1:0]    hacc_q, hacc_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;

    // High-time accumulator follows the same start/count/load strobes as acc
    always_comb begin
        hacc_d      = hacc_q;
        high_time_d = high_time_q;
        if (start_s) begin
            hacc_d = AW'(1);
        end else if (count_s) begin
            hacc_d = hacc_q + AW'(ad_pulse);
        end else begin
            hacc_d = hacc_q;
        end
        if (tmo_fin_s) begin
            high_time_d = {CNT_W{1'b0}};
        end else if (load_s) begin
            high_time_d = hacc_q[AW-1:AVG_LOG2];
        end else begin
            high_time_d = high_time_q;
        end
    end

    // High-time registers
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            hacc_q      <= {AW{1'b0}};
            high_time_q <= {CNT_W{1'b0}};
        end else begin
            hacc_q      <= hacc_d;
            high_time_q <= high_time_d;
        end
    end

    assign high_time = high_time_q;
`else
    assign high_time = {CNT_W{1'b0}};
`endif

    assign meas_valid = meas_valid_q;
    assign period     = period_q;
    assign no_signal  = no_signal_q;

endmodule

// File: tb/tb_pulse_meas.sv
// Scoreboard bench for pulse_meas: directed pulse trains push expected results, a negedge monitor checks them.
module tb_pulse_meas;

    logic        ad_clk = 1'b0;
    logic        rst_n;
    logic        ad_pulse;
    logic        meas_en;
    logic        meas_ready;
    logic        meas_valid;
    logic [23:0] period;
    logic [23:0] high_time;
    logic        no_signal;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [23:0] p;
        logic [23:0] h;
        logic        ns;
    } exp_t;
    exp_t sb[$];

`ifdef PULSE_MEAS_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    pulse_meas #(
        .CNT_W   (24),
        .AVG_LOG2(2),
        .TIMEOUT (32'd1000)
    ) dut (
        .ad_clk    (ad_clk),
        .rst_n     (rst_n),
        .ad_pulse  (ad_pulse),
        .meas_en   (meas_en),
        .meas_ready(meas_ready),
        .meas_valid(meas_valid),
        .period    (period),
        .high_time (high_time),
        .no_signal (no_signal)
    );

    always #5 ad_clk = ~ad_clk;

    function automatic logic [23:0] eh(input logic [23:0] h);
        return DUTY ? h : 24'd0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [23:0] p, input logic [23:0] h, input logic ns);
        exp_t e;
        e.p  = p;
        e.h  = h;
        e.ns = ns;
        sb.push_back(e);
    endtask

    task automatic drive(input logic v);
        ad_pulse = v;
        @(posedge ad_clk);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo);
        repeat (hi) drive(1'b1);
        repeat (lo) drive(1'b0);
    endtask

    // Five rises of a 3-high / 7-low train: expect period 10, high 3
    task automatic basic_meas(input string tag);
        meas_en = 1'b1;
        repeat (3) drive(1'b0);
        repeat (4) pulse(3, 7);
        check({tag, "_pre_final_valid"}, 64'(meas_valid), 64'd0);
        push(24'd10, eh(24'd3), 1'b0);
        drive(1'b1);
        check({tag, "_valid_latency"}, 64'(meas_valid), 64'd1);
        drive(1'b1);
        drive(1'b1);
        meas_en = 1'b0;
        repeat (5) drive(1'b0);
    endtask

    // Monitor: compare every presented result with the scoreboard head, pop on acceptance
    always @(negedge ad_clk) begin
        if (rst_n && meas_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got period=%0d high=%0d no_signal=%0b expected no result",
                         period, high_time, no_signal);
            end else begin
                check("result", {15'd0, period, high_time, no_signal},
                      {15'd0, sb[0].p, sb[0].h, sb[0].ns});
                if (meas_ready) begin
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int found;
        rst_n      = 1'b0;
        ad_pulse   = 1'b0;
        meas_en    = 1'b0;
        meas_ready = 1'b1;
        @(posedge ad_clk);
        @(posedge ad_clk);
        #1;
        check("reset_valid", 64'(meas_valid), 64'd0);
        check("reset_period", 64'(period), 64'd0);
        check("reset_high", 64'(high_time), 64'd0);
        check("reset_no_signal", 64'(no_signal), 64'd0);
        rst_n = 1'b1;

        // Basic 10-cycle period, 3 high
        basic_meas("basic");

        // Alternating 9/11 periods with highs 2,3,2,3
        meas_en = 1'b1;
        repeat (3) drive(1'b0);
        pulse(2, 7);
        pulse(3, 8);
        pulse(2, 7);
        pulse(3, 8);
        push(24'd10, eh(24'd2), 1'b0);
        drive(1'b1);
        check("alt_valid_latency", 64'(meas_valid), 64'd1);
        drive(1'b1);
        meas_en = 1'b0;
        repeat (5) drive(1'b0);

        // Constant low: timeout 1000 cycles after WAIT_EDGE entry
        ad_pulse = 1'b0;
        meas_en  = 1'b1;
        push(24'd0, 24'd0, 1'b1);
        found = 0;
        for (int k = 1; k <= 1100; k++) begin
            @(posedge ad_clk);
            #1;
            if (meas_valid) begin
                found = k;
                break;
            end
        end
        check("timeout_latency", 64'(found), 64'd1001);
        meas_en = 1'b0;
        repeat (3) drive(1'b0);

        // Back-pressure: result held, edges ignored, fresh E0 afterwards
        meas_en    = 1'b1;
        meas_ready = 1'b0;
        repeat (3) drive(1'b0);
        repeat (4) pulse(3, 7);
        push(24'd10, eh(24'd3), 1'b0);
        drive(1'b1);
        check("bp_valid_latency", 64'(meas_valid), 64'd1);
        drive(1'b1);
        drive(1'b1);
        repeat (7) drive(1'b0);
        pulse(3, 7);
        check("bp_held_valid", 64'(meas_valid), 64'd1);
        meas_ready = 1'b1;
        drive(1'b0);
        check("bp_drop_after_accept", 64'(meas_valid), 64'd0);
        push(24'd12, eh(24'd4), 1'b0);
        repeat (4) pulse(4, 8);
        drive(1'b1);
        check("bp_fresh_valid_latency", 64'(meas_valid), 64'd1);
        drive(1'b1);
        meas_en = 1'b0;
        repeat (5) drive(1'b0);

        // Enable dropped after the second edge: no result, then clean re-run
        meas_en = 1'b1;
        repeat (3) drive(1'b0);
        pulse(3, 7);
        drive(1'b1);
        meas_en = 1'b0;
        drive(1'b1);
        drive(1'b1);
        repeat (7) drive(1'b0);
        repeat (3) pulse(3, 7);
        check("abort_no_valid", 64'(meas_valid), 64'd0);
        basic_meas("reenable");

        // Asynchronous reset mid-measurement clears the held result at once
        meas_en = 1'b1;
        repeat (3) drive(1'b0);
        pulse(3, 7);
        pulse(3, 7);
        rst_n = 1'b0;
        #1;
        check("midreset_valid", 64'(meas_valid), 64'd0);
        check("midreset_period", 64'(period), 64'd0);
        check("midreset_high", 64'(high_time), 64'd0);
        check("midreset_no_signal", 64'(no_signal), 64'd0);
        @(posedge ad_clk);
        #1;
        meas_en = 1'b0;
        rst_n   = 1'b1;
        basic_meas("after_reset");

        repeat (10) drive(1'b0);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
